banked_parity_mem: RTL and testbench
====================================

# banked_parity_mem

Parametrised, multi-bank, parity-protected word memory with a registered read port. It generates parity on write and checks it on read, and it self-initialises after reset. Error events are counted and the first failing address is logged. It is the next-generation storage block behind instruction/data fetch: a bank-select field in the upper address bits picks one of `NUM_BANKS` identical banks.

## Interface
- `DATA_W`, 8, data bits per word (stored word is `DATA_W+1` bits, parity in bit 0)
- `BANK_ADDR_W`, 3, word-address bits per bank; `DEPTH = 2**BANK_ADDR_W`
- `NUM_BANKS`, 2, bank count, power of two ≥ 2; `SEL_W = $clog2(NUM_BANKS)`
- `ODD_PARITY`, 0, 0 = even parity (`parity = ^data`), 1 = odd (`parity = ~^data`)
- `ERR_CNT_W`, 8, width of the error counter

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `addr`  in  SEL_W+BANK_ADDR_W  upper `SEL_W` bits = bank, lower = word
- `wr_en`  in  1  write `wdata` to `addr`
- `wdata`  in  DATA_W  write data
- `inj_err`  in  1  with `wr_en`: store inverted parity bit (test hook)
- `rd_en`  in  1  read request at `addr`
- `rdata`  out  DATA_W  read data, valid with `rvalid`
- `rparity`  out  1  stored parity bit of returned word
- `rvalid`  out  1  one-cycle pulse, read data valid
- `par_err`  out  1  one-cycle pulse with `rvalid`, parity mismatch on returned word
- `ready`  out  1  initialisation done, requests accepted
- `err_count`  out  ERR_CNT_W  saturating count of parity errors
- `err_addr`  out  SEL_W+BANK_ADDR_W  address of first error since last clear
- `err_sticky`  out  1  set on first error, held until cleared
- `clr_err`  in  1  clear `err_count`, `err_sticky`, `err_addr`

## Operation
- Reset (async, `rst_n=0`): `rdata=0`, `rparity=0`, `rvalid=0`, `par_err=0`, `ready=0`, `err_count=0`, `err_addr=0`, `err_sticky=0`. Init FSM → `INIT`, `init_idx=0`. Array contents are not reset.
- FSM states: `INIT` → `RUN`.
  - `INIT`: each edge writes word `init_idx` in every bank in parallel with data 0 and the correct parity (0 even, 1 odd). `init_idx` increments; after writing `DEPTH-1`, go to `RUN`.
  - `RUN`: `ready=1`. No return to `INIT` except by reset.
- In `INIT`, `wr_en`, `rd_en` and `clr_err` are ignored and produce no `rvalid`.
- Write (`RUN`, `wr_en`): bank `addr[top]`, word `addr[low]` ← `{wdata, p}`. `p` is the generated parity, XOR `inj_err`.
- Read (`RUN`, `rd_en`): the word is registered onto `rdata`/`rparity` with `rvalid=1` on the next edge. `par_err = (recomputed parity of data != stored bit)`. Otherwise `rvalid=0`, `par_err=0`, and `rdata`/`rparity` hold their last values.
- Simultaneous `wr_en` and `rd_en` (same address, single address port): read returns the OLD contents, and the write commits.
- Error logging on each `par_err`:
  - `err_count` increments, saturating at all-ones.
  - If `err_sticky=0`: `err_addr` ← read address, `err_sticky` ← 1.
- `clr_err` together with a new error in the same cycle: the error wins. Result is `err_count=1`, `err_sticky=1`, `err_addr`=new address.

## Timing
- `ready` rises on the `DEPTH`-th rising edge after `rst_n` deasserts; default is 8 edges.
- Read latency is 1 cycle. Back-to-back reads give one `rvalid` per cycle.
- A write is visible to a read issued on the following cycle.
- `err_*` outputs update on the same edge that asserts `par_err`.
- `rst_n` asserted mid-read: `rvalid` drops immediately, and init restarts after release.

## Test plan
- Reset release, default params: `ready=0` for 7 edges and 1 at edge 8. Then reads of addresses 0..15 each return `rdata=0x00`, `rparity=0`, `par_err=0`.
- Write 0x1F to addr 0 and 0x22 to addr 9, then read both. Required: `0x1F`/`rparity=1` and `0x22`/`rparity=0`, with `rvalid` exactly 1 cycle after each `rd_en` and `par_err=0`.
- Write 0xA5 to addr 3 with `inj_err=1`, then read addr 3. Required: `rdata=0xA5`, `rparity=1`, `par_err=1`, `err_count=1`, `err_sticky=1`, `err_addr=3`. A second error at addr 12 → `err_count=2`, `err_addr` stays 3.
- Same-cycle `wr_en`+`rd_en` on addr 5 (old value 0x00, new 0x77): read returns 0x00. A read on the next cycle returns 0x77.
- `ERR_CNT_W=2`: five injected-error reads → `err_count` saturates at 3. Then `clr_err` with a simultaneous error at addr 6 → `err_count=1`, `err_addr=6`.
- `NUM_BANKS=4`, `ODD_PARITY=1`, and reset asserted mid-init: init restarts from 0. After `ready`, a read of addr 0x1F returns `rdata=0x00`, `rparity=1`, `par_err=0`.

Source files
------------

// File: rtl/banked_parity_mem.sv
// Multi-bank word memory with per-word parity, registered read port,
// self-initialisation after reset and parity-error logging.
module banked_parity_mem #(
  parameter  int DATA_W      = 8,
  parameter  int BANK_ADDR_W = 3,
  parameter  int NUM_BANKS   = 2,
  parameter  int ODD_PARITY  = 0,
  parameter  int ERR_CNT_W   = 8,
  localparam int DEPTH       = 2 ** BANK_ADDR_W,
  localparam int SEL_W       = $clog2(NUM_BANKS),
  localparam int ADDR_W      = SEL_W + BANK_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 inj_err,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rdata,
  output logic                 rparity,
  output logic                 rvalid,
  output logic                 par_err,
  output logic                 ready,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    err_addr,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state;
  logic [BANK_ADDR_W-1:0] r_initIdx;
  logic                   r_ready;
  logic [DATA_W:0]        r_mem [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rparity;
  logic                   r_rvalid;
  logic                   r_parErr;
  logic [ERR_CNT_W-1:0]   r_errCount;
  logic [ADDR_W-1:0]      r_errAddr;
  logic                   r_errSticky;

  logic [SEL_W-1:0]       w_bank;
  logic [BANK_ADDR_W-1:0] w_word;
  logic                   w_run;
  logic                   w_wrAccept;
  logic                   w_rdAccept;
  logic                   w_clrAccept;
  logic [DATA_W:0]        w_rdWord;
  logic                   w_rdMismatch;
  logic                   w_newErr;
  logic [DATA_W:0]        w_initWord;

  function automatic logic genParity(input logic [DATA_W-1:0] d);
    return (ODD_PARITY != 0) ? ~^d : ^d;
  endfunction

  assign w_bank       = addr[ADDR_W-1 -: SEL_W];
  assign w_word       = addr[BANK_ADDR_W-1:0];
  assign w_run        = (r_state == S_RUN);
  assign w_wrAccept   = w_run & wr_en;
  assign w_rdAccept   = w_run & rd_en;
  assign w_clrAccept  = w_run & clr_err;
  assign w_rdWord     = r_mem[w_bank][w_word];
  assign w_rdMismatch = genParity(w_rdWord[DATA_W:1]) != w_rdWord[0];
  assign w_newErr     = w_rdAccept & w_rdMismatch;
  assign w_initWord   = {{DATA_W{1'b0}}, genParity({DATA_W{1'b0}})};

  // Init sweeps one word index across all banks per cycle, then runs forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_initIdx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_initIdx <= r_initIdx + 1'b1;
          if (&r_initIdx) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the init sweep gives every word valid parity.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_mem[b][r_initIdx] <= w_initWord;
      end
    end else if (w_wrAccept) begin
      r_mem[w_bank][w_word] <= {wdata, genParity(wdata) ^ inj_err};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata   <= '0;
      r_rparity <= 1'b0;
      r_rvalid  <= 1'b0;
      r_parErr  <= 1'b0;
    end else begin
      r_rvalid <= w_rdAccept;
      r_parErr <= w_newErr;
      if (w_rdAccept) begin
        r_rdata   <= w_rdWord[DATA_W:1];
        r_rparity <= w_rdWord[0];
      end
    end
  end

  // A fresh error takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCount  <= '0;
      r_errAddr   <= '0;
      r_errSticky <= 1'b0;
    end else if (w_newErr) begin
      if (w_clrAccept) begin
        r_errCount  <= ERR_CNT_W'(1);
        r_errAddr   <= addr;
        r_errSticky <= 1'b1;
      end else begin
        if (!(&r_errCount)) begin
          r_errCount <= r_errCount + 1'b1;
        end
        if (!r_errSticky) begin
          r_errAddr   <= addr;
          r_errSticky <= 1'b1;
        end
      end
    end else if (w_clrAccept) begin
      r_errCount  <= '0;
      r_errAddr   <= '0;
      r_errSticky <= 1'b0;
    end
  end

  assign rdata      = r_rdata;
  assign rparity    = r_rparity;
  assign rvalid     = r_rvalid;
  assign par_err    = r_parErr;
  assign ready      = r_ready;
  assign err_count  = r_errCount;
  assign err_addr   = r_errAddr;
  assign err_sticky = r_errSticky;

endmodule

// File: tb/tb_banked_parity_mem.sv
// Scoreboard bench for banked_parity_mem: a default instance and a 4-bank,
// odd-parity, 2-bit-counter instance share one randomised stimulus stream.
module tb_banked_parity_mem;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] addr;
  logic       wr_en;
  logic [7:0] wdata;
  logic       inj_err;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] aRdata, bRdata;
  logic       aRparity, bRparity, aRvalid, bRvalid, aParErr, bParErr;
  logic       aReady, bReady, aErrSticky, bErrSticky;
  logic [7:0] aErrCount;
  logic [1:0] bErrCount;
  logic [3:0] aErrAddr;
  logic [4:0] bErrAddr;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = default instance, 1 = wide instance.
  logic [8:0] mem [2][32];
  int         cnt [2];
  int         cntMax [2] = '{255, 3};
  bit         oddP [2] = '{1'b0, 1'b1};
  int         amask [2] = '{15, 31};
  bit         sticky [2];
  int         eaddr [2];
  logic [7:0] heldData [2];
  bit         heldPar [2];
  bit         expReady;
  exp_t       q0 [$];
  exp_t       q1 [$];

  banked_parity_mem dutA (
    .clk(clk), .rst_n(rst_n), .addr(addr[3:0]), .wr_en(wr_en), .wdata(wdata),
    .inj_err(inj_err), .rd_en(rd_en), .rdata(aRdata), .rparity(aRparity),
    .rvalid(aRvalid), .par_err(aParErr), .ready(aReady), .err_count(aErrCount),
    .err_addr(aErrAddr), .err_sticky(aErrSticky), .clr_err(clr_err)
  );

  banked_parity_mem #(.NUM_BANKS(4), .ODD_PARITY(1), .ERR_CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .inj_err(inj_err), .rd_en(rd_en), .rdata(bRdata), .rparity(bRparity),
    .rvalid(bRvalid), .par_err(bParErr), .ready(bReady), .err_count(bErrCount),
    .err_addr(bErrAddr), .err_sticky(bErrSticky), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic bit parOf(input logic [7:0] d, input bit odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input int d, input logic rv, input logic [7:0] rd,
                             input logic rp, input logic pe, input logic rdy,
                             input int ec, input int ea, input logic es);
    exp_t e;
    bit   have;
    string p;
    p = $sformatf("dut%0d.", d);
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (rv) begin
      if (!have) begin
        cmp({p, "spurious_rvalid"}, rv, 0);
      end else begin
        heldData[d] = e.data;
        heldPar[d]  = e.par;
        cmp({p, "par_err"}, pe, e.perr);
      end
    end else begin
      if (have) cmp({p, "missing_rvalid"}, rv, 1);
      cmp({p, "par_err_idle"}, pe, 0);
    end
    cmp({p, "rdata"}, rd, heldData[d]);
    cmp({p, "rparity"}, rp, heldPar[d]);
    cmp({p, "ready"}, rdy, expReady);
    cmp({p, "err_count"}, ec, cnt[d]);
    cmp({p, "err_sticky"}, es, sticky[d]);
    cmp({p, "err_addr"}, ea, eaddr[d]);
  endtask

  always @(negedge clk) begin
    checkOutput(0, aRvalid, aRdata, aRparity, aParErr, aReady, aErrCount, aErrAddr, aErrSticky);
    checkOutput(1, bRvalid, bRdata, bRparity, bParErr, bReady, bErrCount, bErrAddr, bErrSticky);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic driveIdle();
    wr_en = 0; rd_en = 0; clr_err = 0; inj_err = 0;
  endtask

  task automatic randInputs();
    wr_en = 1'($urandom); rd_en = 1'($urandom); clr_err = 1'($urandom);
    inj_err = 1'($urandom); addr = 5'($urandom); wdata = 8'($urandom);
  endtask

  // After reset the init sweep leaves every word as data 0 with good parity.
  task automatic modelReset();
    expReady = 0;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; sticky[d] = 0; eaddr[d] = 0; heldData[d] = 0; heldPar[d] = 0;
      for (int w = 0; w < 32; w++) mem[d][w] = {8'h00, parOf(8'h00, oddP[d])};
    end
  endtask

  task automatic doResetInit(input bit abortEarly);
    rst_n = 0;
    modelReset();
    driveIdle();
    step();
    step();
    if (abortEarly) begin
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
        randInputs();
        step();
      end
      rst_n = 0;
      step();
    end
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) expReady = 1;
      randInputs();
      step();
    end
    driveIdle();
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input bit clr, input bit inj,
                               input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    int   ai;
    wr_en = wr; rd_en = rd; clr_err = clr; inj_err = inj; addr = a; wdata = d;
    for (int k = 0; k < 2; k++) begin
      ai = int'(a) & amask[k];
      e.perr = 0;
      if (rd) begin
        e.data = mem[k][ai][8:1];
        e.par  = mem[k][ai][0];
        e.perr = parOf(e.data, oddP[k]) != e.par;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (e.perr) begin
        if (clr) begin
          cnt[k] = 1; sticky[k] = 1; eaddr[k] = ai;
        end else begin
          if (cnt[k] < cntMax[k]) cnt[k]++;
          if (!sticky[k]) begin
            sticky[k] = 1; eaddr[k] = ai;
          end
        end
      end else if (clr) begin
        cnt[k] = 0; sticky[k] = 0; eaddr[k] = 0;
      end
      if (wr) mem[k][ai] = {d, parOf(d, oddP[k]) ^ inj};
    end
    step();
  endtask

  initial begin
    clk = 0;
    rst_n = 1;
    addr = 0;
    wdata = 0;
    driveIdle();
    #1;
    doResetInit(1);

    for (int a = 0; a < 32; a++) applyStimulus(0, 1, 0, 0, 5'(a), 8'h00);

    applyStimulus(1, 0, 0, 0, 5'd0, 8'h1F);
    applyStimulus(1, 0, 0, 0, 5'd9, 8'h22);
    applyStimulus(0, 1, 0, 0, 5'd0, 8'h00);
    applyStimulus(0, 1, 0, 0, 5'd9, 8'h00);

    applyStimulus(1, 0, 0, 1, 5'd3, 8'hA5);
    applyStimulus(0, 1, 0, 0, 5'd3, 8'h00);
    applyStimulus(1, 0, 0, 1, 5'd12, 8'h3C);
    applyStimulus(0, 1, 0, 0, 5'd12, 8'h00);

    applyStimulus(1, 1, 0, 0, 5'd5, 8'h77);
    applyStimulus(0, 1, 0, 0, 5'd5, 8'h00);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 1, 5'(16 + i), 8'($urandom));
      applyStimulus(0, 1, 0, 0, 5'(16 + i), 8'h00);
    end
    applyStimulus(1, 0, 0, 1, 5'd6, 8'h5A);
    applyStimulus(0, 1, 1, 0, 5'd6, 8'h00);
    applyStimulus(0, 0, 1, 0, 5'd0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 5) == 0, 5'($urandom), 8'($urandom));
    end

    applyStimulus(0, 1, 0, 0, 5'h1F, 8'h00);
    rst_n = 0;
    #1;
    cmp("dut0.rvalid_on_reset", aRvalid, 0);
    cmp("dut1.rvalid_on_reset", bRvalid, 0);
    cmp("dut0.rdata_on_reset", aRdata, 0);
    cmp("dut1.rdata_on_reset", bRdata, 0);
    doResetInit(0);
    applyStimulus(0, 1, 0, 0, 5'h1F, 8'h00);
    applyStimulus(0, 0, 0, 0, 5'h00, 8'h00);
    applyStimulus(0, 0, 0, 0, 5'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
